// File: rtl/fft_pkg.sv
// Shared constants for the FFT output path: frame size, index width and the
// output sequencer state encoding.
package fft_pkg;
  localparam int FFT_POINTS = 64;
  localparam int FFT_IDX_W  = 6;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/fft_out_sequencer_if.sv
// Valid/ready output bus carrying one FFT result word with its index and
// an end-of-frame marker.
interface fft_out_sequencer_if #(
  parameter int DATA_LENGTH = 8
);
  logic [DATA_LENGTH-1:0]       out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [fft_pkg::FFT_IDX_W-1:0] out_index;
  logic                         out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_out_reg_slice.sv
// Single-entry valid/ready output register. A new word may be loaded when the
// slot is empty or the current word is being accepted in the same cycle.
module fft_out_reg_slice
  import fft_pkg::*;
#(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DATA_LENGTH-1:0] data,
  input  logic [FFT_IDX_W-1:0]   index,
  input  logic                   last,
  input  logic                   ready,
  output logic                   out_valid,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic [FFT_IDX_W-1:0]   out_index,
  output logic                   out_last,
  output logic                   can_load
);
  logic                   vld_p1;
  logic [DATA_LENGTH-1:0] data_p1;
  logic [FFT_IDX_W-1:0]   index_p1;
  logic                   last_p1;

  assign can_load  = !vld_p1 || ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_index = index_p1;
  assign out_last  = last_p1;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      index_p1 <= '0;
      last_p1  <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      data_p1  <= data;
      index_p1 <= index;
      last_p1  <= last;
    end else if (vld_p1 && ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end
endmodule

// File: rtl/fft_out_sequencer.sv
// Steps the 64-to-1 result mux through 0..63 and streams each word out over a
// valid/ready bus. Optional start-overrun counter: FFT_SEQ_OVERRUN_CNT_EN.
module fft_out_sequencer
  import fft_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int NUM_POINTS  = FFT_POINTS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic [6:0]             mux_sel,
  input  logic [DATA_LENGTH-1:0] mux_data,
  fft_out_sequencer_if.master    bus,
  output logic                   done
`ifdef FFT_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]             overrun_cnt
`endif
);
  localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(NUM_POINTS - 1);

  logic [1:0]             state;
  logic [FFT_IDX_W-1:0]   cnt;
  logic                   load;
  logic                   can_load;
  logic                   valid_q;
  logic [DATA_LENGTH-1:0] data_q;
  logic [FFT_IDX_W-1:0]   index_q;
  logic                   last_q;

  assign mux_sel = {1'b0, cnt};
  assign busy    = (state != IDLE);
  assign load    = (state == RUN) && can_load;

  fft_out_reg_slice #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (mux_data),
    .index    (cnt),
    .last     (cnt == LAST_IDX),
    .ready    (bus.out_ready),
    .out_valid(valid_q),
    .out_data (data_q),
    .out_index(index_q),
    .out_last (last_q),
    .can_load (can_load)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;

  // Sequencer FSM and select counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The final word is already registered; wait for it to be taken.
          if (valid_q && bus.out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (start && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fft_out_sequencer.sv
// Directed bench for fft_out_sequencer: mux model returns 3*sel, each
// scenario task drives stimulus and compares against hand-derived values.
module tb_fft_out_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic [6:0] mux_sel;
  logic [7:0] mux_data;
  logic       done;
`ifdef FFT_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fft_out_sequencer_if #(.DATA_LENGTH(8)) bus ();

  fft_out_sequencer #(
    .DATA_LENGTH(8),
    .NUM_POINTS (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .mux_sel (mux_sel),
    .mux_data(mux_data),
    .bus     (bus.master),
    .done    (done)
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mux_data = 8'({1'b0, mux_sel} * 8'd3);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.out_index !== 6'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", bus.out_index); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mux_sel !== 7'd0) begin errors++; $display("FAIL reset_mux_sel: got %0d expected 0", mux_sel); end
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_free_run();
    int t0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0 || mux_sel !== 7'd0) begin
      errors++; $display("FAIL free_t1: got busy=%b valid=%b sel=%0d expected busy=1 valid=0 sel=0", busy, bus.out_valid, mux_sel);
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 6'(i) || bus.out_data !== 8'(i * 3) ||
          bus.out_last !== (i == 63) || done !== 1'b0) begin
        errors++;
        $display("FAIL free_beat%0d: got valid=%b idx=%0d data=%0d last=%b done=%b expected valid=1 idx=%0d data=%0d last=%b done=0",
                 i, bus.out_valid, bus.out_index, bus.out_data, bus.out_last, done, i, i * 3, (i == 63));
      end
      checks++;
      if (mux_sel !== 7'((i == 63) ? 0 : i + 1)) begin
        errors++; $display("FAIL free_sel%0d: got %0d expected %0d", i, mux_sel, (i == 63) ? 0 : i + 1);
      end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || (cyc - t0) != 66) begin
      errors++; $display("FAIL free_done: got done=%b busy=%b valid=%b at T+%0d expected done=1 busy=0 valid=0 at T+66",
                         done, busy, bus.out_valid, cyc - t0);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL free_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int g = 0;
    int stall_state = 0;
    bit got_done = 1'b0;
    logic [6:0] sel_hold;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!got_done && g < 400) begin
      g++;
      if (stall_state == 0 && bus.out_valid && bus.out_index == 6'd10) begin
        bus.out_ready = 1'b0;
        sel_hold = mux_sel;
        repeat (5) begin
          tick();
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd10 || bus.out_data !== 8'd30 || mux_sel !== sel_hold) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b idx=%0d data=%0d sel=%0d expected valid=1 idx=10 data=30 sel=%0d",
                     bus.out_valid, bus.out_index, bus.out_data, mux_sel, sel_hold);
          end
        end
        stall_state = 1;
        bus.out_ready = 1'b1;
      end else if (stall_state == 1) begin
        bus.out_ready = ~bus.out_ready;
      end
      if (done) got_done = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_index !== exp_idx[5:0] || bus.out_data !== 8'(exp_idx * 3) || bus.out_last !== (exp_idx == 63)) begin
          errors++;
          $display("FAIL bp_beat: got idx=%0d data=%0d last=%b expected idx=%0d data=%0d last=%b",
                   bus.out_index, bus.out_data, bus.out_last, exp_idx, exp_idx * 3, (exp_idx == 63));
        end
        exp_idx++;
      end
      if (!got_done) tick();
    end
    bus.out_ready = 1'b1;
    checks++; if (exp_idx != 64 || !got_done) begin
      errors++; $display("FAIL bp_count: got %0d words done=%b expected 64 words done=1", exp_idx, got_done);
    end
    tick();
  endtask

  task automatic test_last_stall();
    int g = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!(bus.out_valid === 1'b1 && bus.out_index === 6'd63) && g < 100) begin
      g++;
      tick();
    end
    checks++; if (g >= 100) begin errors++; $display("FAIL last_wait: got timeout expected index 63"); end
    bus.out_ready = 1'b0;
    repeat (4) begin
      checks++;
      if (dut.state !== 2'd2 || busy !== 1'b1 || done !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
        errors++;
        $display("FAIL last_stall: got state=%0d busy=%b done=%b valid=%b last=%b expected state=2 busy=1 done=0 valid=1 last=1",
                 dut.state, busy, done, bus.out_valid, bus.out_last);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL last_release: got done=%b busy=%b valid=%b last=%b expected done=1 busy=0 valid=0 last=0",
                         done, busy, bus.out_valid, bus.out_last);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL last_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_start_busy();
    int exp_idx = 0;
    int dones = 0;
    int g = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (dones == 0 && g < 200) begin
      g++;
      start = bus.out_valid && (bus.out_index == 6'd20 || bus.out_index == 6'd63);
      if (done) dones++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_index !== exp_idx[5:0] || bus.out_data !== 8'(exp_idx * 3)) begin
          errors++; $display("FAIL sb_beat: got idx=%0d data=%0d expected idx=%0d data=%0d",
                             bus.out_index, bus.out_data, exp_idx, exp_idx * 3);
        end
        exp_idx++;
      end
      if (dones == 0) tick();
    end
    start = 1'b0;
    checks++; if (exp_idx != 64 || dones != 1) begin
      errors++; $display("FAIL sb_count: got %0d words %0d dones expected 64 words 1 done", exp_idx, dones);
    end
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL sb_idle: got busy=%b valid=%b expected busy=0 valid=0", busy, bus.out_valid);
    end
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    checks++; if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL sb_overrun: got %0d expected 2", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int exp_idx = 0;
    int g = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!(bus.out_valid === 1'b1 && bus.out_index === 6'd30) && g < 100) begin
      g++;
      tick();
    end
    checks++; if (g >= 100) begin errors++; $display("FAIL rm_wait: got timeout expected index 30"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || mux_sel !== 7'd0 || done !== 1'b0 || bus.out_index !== 6'd0) begin
      errors++; $display("FAIL rm_after: got valid=%b busy=%b sel=%0d done=%b idx=%0d expected all 0",
                         bus.out_valid, busy, mux_sel, done, bus.out_index);
    end
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rm_overrun: got %0d expected 0", overrun_cnt); end
`endif
    repeat (3) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rm_quiet: got done=%b busy=%b valid=%b expected 0 0 0", done, busy, bus.out_valid);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (!done && g < 200) begin
      g++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_index !== exp_idx[5:0] || bus.out_data !== 8'(exp_idx * 3)) begin
          errors++; $display("FAIL rm_beat: got idx=%0d data=%0d expected idx=%0d data=%0d",
                             bus.out_index, bus.out_data, exp_idx, exp_idx * 3);
        end
        exp_idx++;
      end
      tick();
    end
    checks++; if (exp_idx != 64 || done !== 1'b1) begin
      errors++; $display("FAIL rm_count: got %0d words done=%b expected 64 words done=1", exp_idx, done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_idx = 0;
    int g = 0;
    int t_done;
    int t_first = -1;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && g < 200) begin
      g++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_index !== exp_idx[5:0] || bus.out_data !== 8'(exp_idx * 3)) begin
          errors++; $display("FAIL b2b_a_beat: got idx=%0d data=%0d expected idx=%0d data=%0d",
                             bus.out_index, bus.out_data, exp_idx, exp_idx * 3);
        end
        exp_idx++;
      end
      tick();
    end
    checks++; if (exp_idx != 64 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_a_count: got %0d words done=%b expected 64 words done=1", exp_idx, done);
    end
    start = 1'b1;
    t_done = cyc;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got busy=%b valid=%b expected busy=1 valid=0", busy, bus.out_valid);
    end
    exp_idx = 0;
    g = 0;
    while (!done && g < 200) begin
      g++;
      if (bus.out_valid && bus.out_ready) begin
        if (t_first < 0) t_first = cyc;
        checks++;
        if (bus.out_index !== exp_idx[5:0] || bus.out_data !== 8'(exp_idx * 3) || bus.out_last !== (exp_idx == 63)) begin
          errors++; $display("FAIL b2b_b_beat: got idx=%0d data=%0d last=%b expected idx=%0d data=%0d last=%b",
                             bus.out_index, bus.out_data, bus.out_last, exp_idx, exp_idx * 3, (exp_idx == 63));
        end
        exp_idx++;
      end
      tick();
    end
    checks++; if (exp_idx != 64 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_b_count: got %0d words done=%b expected 64 words done=1", exp_idx, done);
    end
    checks++; if (t_first - t_done != 2) begin
      errors++; $display("FAIL b2b_latency: got first word %0d cycles after done expected 2", t_first - t_done);
    end
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_free_run();
    test_backpressure();
    test_last_stall();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
